pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline control block that drives the stall and validity inputs of the ID/RR and RR/EX pipeline registers. Takes RR-stage and EX-stage instruction fields and generates load-use bubbles, branch/jump flushes, LM/SM micro-op sequencing and halt. It is the producer of `stall_RR` and `in_Validity_RR_EX`, sitting between the RR-stage decode outputs and the RR/EX register.

## Interface
Parameters:
- none

Ports:
- `clk` input 1: pipeline clock; state registers update on negedge, matching the pipeline registers.
- `resetn` input 1: asynchronous, active-low reset.
- `rr_valid` input 1: RR stage holds a valid instruction.
- `rr_src0`, `rr_src1` input 3 each: source register indices of the RR instruction.
- `rr_src0_used`, `rr_src1_used` input 1 each: source is actually read.
- `rr_LMStart` input 2: nonzero marks an LM/SM instruction.
- `rr_LM_regs` input 8: LM/SM register list; bit i selects R[i].
- `ex_valid` input 1: EX stage valid (RR/EX register validity output).
- `ex_mem_ans` input 1: EX instruction is a load.
- `ex_W_reg` input 1: EX instruction writes a register.
- `ex_RDest` input 3: EX destination register.
- `ex_Jump` input 2: nonzero means a redirect resolved in EX.
- `ex_stop` input 1: EX instruction is a halt.
- `stall_IF`, `stall_ID` output 1 each: hold the PC and the IF/ID register.
- `stall_ID_RR` output 1: hold the ID/RR register.
- `stall_RR` output 1: hold the RR/EX register.
- `valid_ID_RR` output 1: validity into the ID/RR register.
- `valid_RR_EX` output 1: validity into the RR/EX register (`in_Validity_RR_EX`).
- `lm_index` output 3: register index of the current LM/SM micro-op.
- `lm_first`, `lm_last` output 1 each: current micro-op is the first or the last.
- `halted` output 1: core halted.

## Operation
- States: RUN, MULTI, HALT. Internal `lm_mask[7:0]` holds the remaining register list.
- Outputs are combinational from state and inputs. Priority order: HALT, then flush, then load-use, then MULTI/LM, then normal.
- **HALT**: entered when `ex_valid & ex_stop`.
  - In HALT: `stall_IF = stall_ID = stall_ID_RR = 1`, `valid_RR_EX = 0`, `halted = 1`.
  - HALT is left only by reset.
- **Flush**: when `ex_valid & (ex_Jump != 0)` in RUN or MULTI:
  - `valid_ID_RR = 0` and `valid_RR_EX = 0` for that cycle; all stalls 0.
  - Any MULTI sequence is aborted: state goes to RUN and `lm_mask` is cleared.
- **Load-use**: asserted when all of the following hold:
  - `rr_valid & ex_valid & ex_mem_ans & ex_W_reg`;
  - `ex_RDest` equals a used source (`rr_src0` with `rr_src0_used`, or `rr_src1` with `rr_src1_used`).
  - Response: `stall_IF = stall_ID = stall_ID_RR = 1`, `stall_RR = 0`, `valid_RR_EX = 0`, giving one bubble into EX.
  - The condition clears by itself the next cycle because the load moves to MEM.
- **LM/SM**: in RUN, with `rr_valid`, `rr_LMStart != 0`, no flush and no load-use; let k = popcount(`rr_LM_regs`).
  - k = 0: `valid_RR_EX = 0` for one cycle; no stall.
  - k = 1: a single micro-op with `lm_index` = the set bit, `lm_first = lm_last = 1`; no stall.
  - k ≥ 2: first micro-op uses the lowest set bit, `lm_first = 1`. `stall_IF = stall_ID = stall_ID_RR = 1`. `lm_mask` loads `rr_LM_regs` with that bit cleared, and state goes to MULTI.
  - In MULTI: `lm_index` = the lowest set bit of `lm_mask`, `valid_RR_EX = 1`, stalls held, and that bit is cleared each cycle. When one bit remains, `lm_last = 1`, stalls release, and state returns to RUN.
- Micro-ops are issued in ascending register order. Exactly k valid micro-ops enter EX.
- **Normal**: all stalls 0, `valid_ID_RR = 1`, `valid_RR_EX = rr_valid`.

## Timing
- Stall and validity outputs are combinational within the cycle. They are sampled by the pipeline registers on the next negedge `clk`.
- State and `lm_mask` update on negedge `clk`.
- LM/SM latency: k cycles of EX issue, with k−1 cycles of front-end stall.
- Load-use penalty: exactly 1 bubble.
- Flush penalty: 2 invalidated slots (ID/RR and RR/EX) in one cycle.
- Reset (asynchronous, any state, including mid-MULTI or HALT): state RUN, `lm_mask = 0`.
- While `resetn = 0`: all stalls 0, `valid_ID_RR = 0`, `valid_RR_EX = 0`, `lm_index = 0`, `lm_first = lm_last = 0`, `halted = 0`.
- Flush and load-use in the same cycle: flush wins, so no stall is asserted.
- `ex_stop` together with `ex_Jump`: HALT wins.

## Configuration
- `HAZ_LOAD_USE_EN` defined: load-use interlock as specified above.
- Not defined: the load-use detector is removed. Load-use never stalls and the software schedules around it. Flush, LM/SM and HALT are unchanged.

## Test plan
- **Load-use:** EX holds a valid load with `ex_RDest = 3`; RR reads R3 (`rr_src1 = 3`, used) → one cycle with `stall_IF = stall_ID_RR = 1`, `stall_RR = 0`, `valid_RR_EX = 0`; normal the next cycle. With the macro undefined → no stall.
- **LM/SM sequence:** `rr_LMStart = 01`, `rr_LM_regs = 8'b1010_0110` → `lm_index` sequence 1, 2, 5, 7 over 4 cycles. `lm_first` is set on cycle 1 and `lm_last` on cycle 4. Stalls are high on cycles 1–3 and low on cycle 4.
- **Flush mid-MULTI:** `ex_Jump = 10` with `ex_valid` during the 2nd micro-op → `valid_ID_RR = valid_RR_EX = 0` that cycle; state RUN; `lm_mask = 0`.
- **Halt:** `ex_valid`, `ex_stop = 1`, `ex_Jump = 01` → `halted = 1`, front-end stalled, `valid_RR_EX = 0`, held for 10 cycles until `resetn` is pulsed low.
- **LM/SM edge cases:** `rr_LM_regs = 0` → one bubble, no stall. `rr_LM_regs = 8'h10` → single micro-op with `lm_index = 4`, `lm_first = lm_last = 1`.
- **Async reset:** `resetn` dropped mid-MULTI, between clock edges → outputs go to their reset values immediately; after release, state is RUN.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard control bundle: RR/EX instruction fields in, stall/validity/LM sequencing out.
// master = pipeline datapath side, slave = hazard controller side.
interface pipe_hazard_ctrl_if;
  logic       rr_valid;
  logic [2:0] rr_src0;
  logic [2:0] rr_src1;
  logic       rr_src0_used;
  logic       rr_src1_used;
  logic [1:0] rr_LMStart;
  logic [7:0] rr_LM_regs;
  logic       ex_valid;
  logic       ex_mem_ans;
  logic       ex_W_reg;
  logic [2:0] ex_RDest;
  logic [1:0] ex_Jump;
  logic       ex_stop;

  logic       stall_IF;
  logic       stall_ID;
  logic       stall_ID_RR;
  logic       stall_RR;
  logic       valid_ID_RR;
  logic       valid_RR_EX;
  logic [2:0] lm_index;
  logic       lm_first;
  logic       lm_last;
  logic       halted;

  modport master (
    output rr_valid, rr_src0, rr_src1, rr_src0_used, rr_src1_used, rr_LMStart, rr_LM_regs,
    output ex_valid, ex_mem_ans, ex_W_reg, ex_RDest, ex_Jump, ex_stop,
    input  stall_IF, stall_ID, stall_ID_RR, stall_RR, valid_ID_RR, valid_RR_EX,
    input  lm_index, lm_first, lm_last, halted
  );

  modport slave (
    input  rr_valid, rr_src0, rr_src1, rr_src0_used, rr_src1_used, rr_LMStart, rr_LM_regs,
    input  ex_valid, ex_mem_ans, ex_W_reg, ex_RDest, ex_Jump, ex_stop,
    output stall_IF, stall_ID, stall_ID_RR, stall_RR, valid_ID_RR, valid_RR_EX,
    output lm_index, lm_first, lm_last, halted
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: halt, branch flush, load-use bubble and LM/SM micro-op sequencing.
// Outputs are combinational from state and inputs; state updates on negedge clk like the pipe regs.
// Optional: define HAZ_LOAD_USE_EN to include the load-use interlock.
module pipe_hazard_ctrl (
  input  logic                clk,
  input  logic                resetn,
  pipe_hazard_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {RUN, MULTI, HALT} state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_lm_mask;
  logic [7:0] w_next_mask;

  logic       w_halt_req;
  logic       w_flush;
  logic       w_load_use;
  logic [7:0] w_rr_low;
  logic       w_rr_multi;
  logic [7:0] w_mask_low;
  logic       w_mask_last;

  logic       w_stall_fe;
  logic       w_valid_id_rr;
  logic       w_valid_rr_ex;
  logic [2:0] w_lm_index;
  logic       w_lm_first;
  logic       w_lm_last;
  logic       w_halted;

  // Index of the lowest set bit of a register list.
  function automatic logic [2:0] low_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign w_halt_req = bus.ex_valid & bus.ex_stop;
  assign w_flush    = bus.ex_valid & (bus.ex_Jump != 2'b00);

`ifdef HAZ_LOAD_USE_EN
  assign w_load_use = bus.rr_valid & bus.ex_valid & bus.ex_mem_ans & bus.ex_W_reg &
                      ((bus.rr_src0_used & (bus.rr_src0 == bus.ex_RDest)) |
                       (bus.rr_src1_used & (bus.rr_src1 == bus.ex_RDest)));
`else
  logic w_unused_lu;
  assign w_unused_lu = ^{bus.rr_src0, bus.rr_src1, bus.rr_src0_used, bus.rr_src1_used,
                         bus.ex_mem_ans, bus.ex_W_reg, bus.ex_RDest};
  assign w_load_use  = 1'b0;
`endif

  // Lowest-bit isolation for the incoming list and for the remaining mask.
  assign w_rr_low    = bus.rr_LM_regs & (~bus.rr_LM_regs + 8'd1);
  assign w_rr_multi  = (bus.rr_LM_regs & (bus.rr_LM_regs - 8'd1)) != 8'd0;
  assign w_mask_low  = r_lm_mask & (~r_lm_mask + 8'd1);
  assign w_mask_last = (r_lm_mask & (r_lm_mask - 8'd1)) == 8'd0;

  // Prioritised next-state and output decode: reset, halt, flush, load-use, MULTI/LM, normal.
  always_comb begin
    w_next_state  = r_state;
    w_next_mask   = r_lm_mask;
    w_stall_fe    = 1'b0;
    w_valid_id_rr = 1'b1;
    w_valid_rr_ex = bus.rr_valid;
    w_lm_index    = 3'd0;
    w_lm_first    = 1'b0;
    w_lm_last     = 1'b0;
    w_halted      = 1'b0;

    if (!resetn) begin
      w_next_state  = RUN;
      w_next_mask   = 8'd0;
      w_valid_id_rr = 1'b0;
      w_valid_rr_ex = 1'b0;
    end else if ((r_state == HALT) || w_halt_req) begin
      w_next_state  = HALT;
      w_next_mask   = 8'd0;
      w_stall_fe    = 1'b1;
      w_valid_id_rr = 1'b0;
      w_valid_rr_ex = 1'b0;
      w_halted      = 1'b1;
    end else if (w_flush) begin
      w_next_state  = RUN;
      w_next_mask   = 8'd0;
      w_valid_id_rr = 1'b0;
      w_valid_rr_ex = 1'b0;
    end else if (w_load_use) begin
      w_stall_fe    = 1'b1;
      w_valid_rr_ex = 1'b0;
    end else if (r_state == MULTI) begin
      w_lm_index    = low_idx(r_lm_mask);
      w_valid_rr_ex = 1'b1;
      w_next_mask   = r_lm_mask & ~w_mask_low;
      if (w_mask_last) begin
        w_lm_last    = 1'b1;
        w_next_state = RUN;
      end else begin
        w_stall_fe   = 1'b1;
      end
    end else if (bus.rr_valid && (bus.rr_LMStart != 2'b00)) begin
      if (bus.rr_LM_regs == 8'd0) begin
        w_valid_rr_ex = 1'b0;
      end else begin
        w_lm_index = low_idx(bus.rr_LM_regs);
        w_lm_first = 1'b1;
        if (w_rr_multi) begin
          w_stall_fe   = 1'b1;
          w_next_mask  = bus.rr_LM_regs & ~w_rr_low;
          w_next_state = MULTI;
        end else begin
          w_lm_last    = 1'b1;
        end
      end
    end
  end

  // State and remaining LM list, updated on the pipeline's negedge.
  always_ff @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= RUN;
      r_lm_mask <= 8'd0;
    end else begin
      r_state   <= w_next_state;
      r_lm_mask <= w_next_mask;
    end
  end

  assign bus.stall_IF    = w_stall_fe;
  assign bus.stall_ID    = w_stall_fe;
  assign bus.stall_ID_RR = w_stall_fe;
  assign bus.stall_RR    = 1'b0;
  assign bus.valid_ID_RR = w_valid_id_rr;
  assign bus.valid_RR_EX = w_valid_rr_ex;
  assign bus.lm_index    = w_lm_index;
  assign bus.lm_first    = w_lm_first;
  assign bus.lm_last     = w_lm_last;
  assign bus.halted      = w_halted;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised bench for pipe_hazard_ctrl against a queue-based reference model, plus directed scenarios.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic resetn;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: halted flag and queue of LM register indices still to issue.
  bit m_halted = 1'b0;
  int m_pending[$];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Evaluate the model for the current inputs, compare every output, then advance the model.
  task automatic step_check();
    logic       e_st, e_vir, e_vre, e_first, e_last, e_halt, vir_care, idx_care, lu;
    logic [2:0] e_idx;
    int         lst[$];
    e_st = 1'b0; e_vir = 1'b1; e_vre = bus.rr_valid; e_first = 1'b0; e_last = 1'b0;
    e_halt = 1'b0; vir_care = 1'b0; idx_care = 1'b0; e_idx = 3'd0; lu = 1'b0;
`ifdef HAZ_LOAD_USE_EN
    lu = bus.rr_valid && bus.ex_valid && bus.ex_mem_ans && bus.ex_W_reg &&
         ((bus.rr_src0_used && (bus.rr_src0 == bus.ex_RDest)) ||
          (bus.rr_src1_used && (bus.rr_src1 == bus.ex_RDest)));
`endif
    if (!resetn) begin
      e_vir = 1'b0; vir_care = 1'b1; e_vre = 1'b0; idx_care = 1'b1;
      m_halted = 1'b0; m_pending.delete();
    end else if (m_halted || (bus.ex_valid && bus.ex_stop)) begin
      e_st = 1'b1; e_vre = 1'b0; e_halt = 1'b1;
      m_halted = 1'b1; m_pending.delete();
    end else if (bus.ex_valid && (bus.ex_Jump != 2'b00)) begin
      e_vir = 1'b0; vir_care = 1'b1; e_vre = 1'b0;
      m_pending.delete();
    end else if (lu) begin
      e_st = 1'b1; e_vre = 1'b0;
    end else if (m_pending.size() > 0) begin
      idx_care = 1'b1;
      e_idx    = 3'(m_pending.pop_front());
      e_vre    = 1'b1;
      e_last   = (m_pending.size() == 0);
      e_st     = !e_last;
    end else if (bus.rr_valid && (bus.rr_LMStart != 2'b00)) begin
      for (int i = 0; i < 8; i++) if (bus.rr_LM_regs[i]) lst.push_back(i);
      if (lst.size() == 0) begin
        e_vre = 1'b0;
      end else begin
        idx_care  = 1'b1;
        e_idx     = 3'(lst.pop_front());
        e_first   = 1'b1;
        e_last    = (lst.size() == 0);
        e_st      = !e_last;
        m_pending = lst;
      end
    end else begin
      vir_care = 1'b1;
    end

    check("stall_IF",    8'(bus.stall_IF),    8'(e_st));
    check("stall_ID",    8'(bus.stall_ID),    8'(e_st));
    check("stall_ID_RR", 8'(bus.stall_ID_RR), 8'(e_st));
    check("stall_RR",    8'(bus.stall_RR),    8'd0);
    check("valid_RR_EX", 8'(bus.valid_RR_EX), 8'(e_vre));
    if (vir_care) check("valid_ID_RR", 8'(bus.valid_ID_RR), 8'(e_vir));
    if (idx_care) check("lm_index",    8'(bus.lm_index),    8'(e_idx));
    check("lm_first",    8'(bus.lm_first),    8'(e_first));
    check("lm_last",     8'(bus.lm_last),     8'(e_last));
    check("halted",      8'(bus.halted),      8'(e_halt));
  endtask

  task automatic set_in(input logic rv, input logic [2:0] s0, input logic [2:0] s1,
                        input logic u0, input logic u1, input logic [1:0] lms,
                        input logic [7:0] regs, input logic ev, input logic mem,
                        input logic wr, input logic [2:0] rd, input logic [1:0] jmp,
                        input logic stop);
    bus.rr_valid = rv; bus.rr_src0 = s0; bus.rr_src1 = s1;
    bus.rr_src0_used = u0; bus.rr_src1_used = u1;
    bus.rr_LMStart = lms; bus.rr_LM_regs = regs;
    bus.ex_valid = ev; bus.ex_mem_ans = mem; bus.ex_W_reg = wr;
    bus.ex_RDest = rd; bus.ex_Jump = jmp; bus.ex_stop = stop;
  endtask

  task automatic drive(input logic rv, input logic [2:0] s0, input logic [2:0] s1,
                       input logic u0, input logic u1, input logic [1:0] lms,
                       input logic [7:0] regs, input logic ev, input logic mem,
                       input logic wr, input logic [2:0] rd, input logic [1:0] jmp,
                       input logic stop);
    @(posedge clk);
    set_in(rv, s0, s1, u0, u1, lms, regs, ev, mem, wr, rd, jmp, stop);
    #1 step_check();
  endtask

  task automatic drive_random();
    logic [7:0] regs;
    case ($urandom_range(0, 3))
      0:       regs = 8'd0;
      1:       regs = 8'(1 << $urandom_range(0, 7));
      default: regs = 8'($urandom);
    endcase
    @(posedge clk);
    set_in(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, regs,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
           ($urandom_range(0, 299) == 0));
    #1 step_check();
  endtask

  // Drop reset between clock edges, check outputs at once, hold over a negedge, release.
  task automatic async_reset_pulse();
    #1 resetn = 1'b0;
    #1 step_check();
    @(negedge clk);
    #2 resetn = 1'b1;
  endtask

  logic [2:0] lm_seq [4];
  int         halt_cnt;

  initial begin
    lm_seq[0] = 3'd1; lm_seq[1] = 3'd2; lm_seq[2] = 3'd5; lm_seq[3] = 3'd7;
    resetn = 1'b0;
    set_in(1, 0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 0, 0, 0);
    #2 step_check();
    @(negedge clk);
    #2 resetn = 1'b1;

    // Load-use on R3, then the cycle after.
    drive(1, 3'd0, 3'd3, 0, 1, 2'b00, 8'd0, 1, 1, 1, 3'd3, 2'b00, 0);
    drive(1, 3'd0, 3'd3, 0, 1, 2'b00, 8'd0, 0, 0, 0, 3'd0, 2'b00, 0);

    // LM/SM list 1010_0110 issues 1,2,5,7.
    for (int c = 0; c < 4; c++) begin
      drive(1, 3'd0, 3'd0, 0, 0, 2'b01, 8'hA6, 0, 0, 0, 3'd0, 2'b00, 0);
      check("lm_seq", 8'(bus.lm_index), 8'(lm_seq[c]));
    end
    drive(1, 3'd0, 3'd0, 0, 0, 2'b00, 8'd0, 0, 0, 0, 3'd0, 2'b00, 0);

    // Flush during the second micro-op aborts the sequence.
    drive(1, 3'd0, 3'd0, 0, 0, 2'b01, 8'hA6, 0, 0, 0, 3'd0, 2'b00, 0);
    drive(1, 3'd0, 3'd0, 0, 0, 2'b01, 8'hA6, 1, 0, 0, 3'd0, 2'b10, 0);
    drive(1, 3'd0, 3'd0, 0, 0, 2'b00, 8'd0, 0, 0, 0, 3'd0, 2'b00, 0);

    // Empty list and single-register list.
    drive(1, 3'd0, 3'd0, 0, 0, 2'b01, 8'h00, 0, 0, 0, 3'd0, 2'b00, 0);
    drive(1, 3'd0, 3'd0, 0, 0, 2'b01, 8'h10, 0, 0, 0, 3'd0, 2'b00, 0);
    check("lm_single", 8'(bus.lm_index), 8'd4);
    drive(1, 3'd0, 3'd0, 0, 0, 2'b00, 8'd0, 0, 0, 0, 3'd0, 2'b00, 0);

    // Halt with a simultaneous jump, held until reset.
    drive(1, 3'd0, 3'd0, 0, 0, 2'b00, 8'd0, 1, 0, 0, 3'd0, 2'b01, 1);
    for (int c = 0; c < 10; c++) drive_random();
    async_reset_pulse();
    drive(1, 3'd0, 3'd0, 0, 0, 2'b00, 8'd0, 0, 0, 0, 3'd0, 2'b00, 0);

    // Asynchronous reset mid-MULTI.
    drive(1, 3'd0, 3'd0, 0, 0, 2'b01, 8'hA6, 0, 0, 0, 3'd0, 2'b00, 0);
    drive(1, 3'd0, 3'd0, 0, 0, 2'b01, 8'hA6, 0, 0, 0, 3'd0, 2'b00, 0);
    async_reset_pulse();
    drive(1, 3'd0, 3'd0, 0, 0, 2'b00, 8'd0, 0, 0, 0, 3'd0, 2'b00, 0);

    // Random traffic; a halted core is released by reset after a while.
    halt_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      drive_random();
      if (m_halted) halt_cnt++;
      if (halt_cnt >= 10 || $urandom_range(0, 499) == 0) begin
        async_reset_pulse();
        halt_cnt = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
